// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, synchronous flush to a bubble,
// and an optional 2-entry skid buffer that makes in_ready a pure flop.
module pipe_stage_reg #(
  parameter int unsigned       CTRL_W      = 8,
  parameter int unsigned       DATA_W      = 47,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter int unsigned       SKID        = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam bit SKID_EN = (SKID != 0);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                accept;
  logic                retire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;
  assign in_ready  = SKID_EN ? in_ready_q : ((state_q == ST_EMPTY) || out_ready);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;

  // Next-state and datapath selection; flush overrides every transfer.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = CTRL_BUBBLE;
      main_data_d = {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_FULL;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept && retire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept && SKID_EN) begin
            state_d     = ST_SKID;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (retire) begin
            // Going empty: present a bubble so downstream decode stays inert.
            state_d     = ST_EMPTY;
            main_ctrl_d = CTRL_BUBBLE;
            main_data_d = {DATA_W{1'b0}};
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID: begin
          if (retire) begin
            state_d     = ST_FULL;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = CTRL_BUBBLE;
          main_data_d = {DATA_W{1'b0}};
        end
      endcase
    end
    in_ready_d = (state_d != ST_SKID);
  end

  // State and entry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= CTRL_BUBBLE;
      main_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: lane 0 is a SKID=0 build, lane 1 a SKID=1 build,
// each tracked every cycle by a FIFO scoreboard plus directed checks.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 47;
  localparam logic [CW-1:0] BUB = 8'h5A;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [CW-1:0] in_ctrl   [2];
  logic [DW-1:0] in_data   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [CW-1:0] out_ctrl  [2];
  logic [DW-1:0] out_data  [2];
  logic [1:0]    occupancy [2];

  int n_checks = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_passed++;
    else $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int g, input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid[g] = v;
    in_ctrl[g]  = c;
    in_data[g]  = d;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [CW+DW-1:0] sb [$];
    logic             exp_rdy;

    pipe_stage_reg #(
      .CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE(BUB), .SKID(g)
    ) u_dut (
      .clk(clk), .reset(reset), .flush(flush[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_ctrl(in_ctrl[g]), .in_data(in_data[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_ctrl(out_ctrl[g]), .out_data(out_data[g]),
      .occupancy(occupancy[g])
    );

    // Scoreboard: compare held entry with the model front, then apply this cycle's transfers.
    always @(negedge clk) begin
      if (reset) begin
        sb.delete();
      end else begin
        exp_rdy = (g == 1) ? (sb.size() < 2) : ((sb.size() == 0) || out_ready[g]);
        check_eq($sformatf("L%0d_occ", g), 64'(occupancy[g]), 64'(sb.size()));
        check_eq($sformatf("L%0d_valid", g), 64'(out_valid[g]), 64'(sb.size() != 0));
        check_eq($sformatf("L%0d_in_ready", g), 64'(in_ready[g]), 64'(exp_rdy));
        if (out_valid[g] && sb.size() != 0) begin
          check_eq($sformatf("L%0d_entry", g), 64'({out_ctrl[g], out_data[g]}), 64'(sb[0]));
          if (out_ready[g]) void'(sb.pop_front());
        end else if (!out_valid[g]) begin
          check_eq($sformatf("L%0d_bubble", g), 64'(out_ctrl[g]), 64'(BUB));
        end
        if (flush[g]) sb.delete();
        else if (in_valid[g] && in_ready[g]) sb.push_back({in_ctrl[g], in_data[g]});
      end
    end
  end

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      flush[g] = 1'b0;
      out_ready[g] = 1'b0;
      drive(g, 1'b0, 8'h00, 47'h0);
    end
    repeat (2) cyc();
    for (int g = 0; g < 2; g++) begin
      check_eq("rst_valid", 64'(out_valid[g]), 64'd0);
      check_eq("rst_ctrl", 64'(out_ctrl[g]), 64'(BUB));
      check_eq("rst_data", 64'(out_data[g]), 64'd0);
      check_eq("rst_occ", 64'(occupancy[g]), 64'd0);
    end
    check_eq("rst_in_ready", 64'(in_ready[1]), 64'd1);
    reset = 1'b0;
    cyc();

    // Back-to-back streaming through the skid lane.
    out_ready[1] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive(1, 1'b1, CW'(i), DW'(i));
      cyc();
      check_eq("stream_valid", 64'(out_valid[1]), 64'd1);
      check_eq("stream_ctrl", 64'(out_ctrl[1]), 64'(i));
      check_eq("stream_data", 64'(out_data[1]), 64'(i));
      check_eq("stream_rdy", 64'(in_ready[1]), 64'd1);
    end
    drive(1, 1'b0, 8'h00, 47'h0);
    cyc();
    check_eq("stream_drain", 64'(occupancy[1]), 64'd0);

    // Stall fills the skid entry; outputs must hold A.
    out_ready[1] = 1'b0;
    drive(1, 1'b1, 8'hAA, 47'h1234); cyc();
    drive(1, 1'b1, 8'hBB, 47'h5678); cyc();
    drive(1, 1'b0, 8'h00, 47'h0);
    repeat (2) begin
      check_eq("stall_occ", 64'(occupancy[1]), 64'd2);
      check_eq("stall_rdy", 64'(in_ready[1]), 64'd0);
      check_eq("stall_ctrl", 64'(out_ctrl[1]), 64'hAA);
      check_eq("stall_data", 64'(out_data[1]), 64'h1234);
      cyc();
    end
    out_ready[1] = 1'b1;
    cyc();
    check_eq("release_ctrl", 64'(out_ctrl[1]), 64'hBB);
    check_eq("release_occ", 64'(occupancy[1]), 64'd1);
    check_eq("release_rdy", 64'(in_ready[1]), 64'd1);
    cyc();
    check_eq("release_empty", 64'(out_valid[1]), 64'd0);
    out_ready[1] = 1'b0;

    // Flush with two held entries and C offered.
    drive(1, 1'b1, 8'hAA, 47'h1); cyc();
    drive(1, 1'b1, 8'hBB, 47'h2); cyc();
    check_eq("pre_flush_occ", 64'(occupancy[1]), 64'd2);
    flush[1] = 1'b1;
    drive(1, 1'b1, 8'hCC, 47'h3);
    cyc();
    flush[1] = 1'b0;
    drive(1, 1'b0, 8'h00, 47'h0);
    check_eq("flush_valid", 64'(out_valid[1]), 64'd0);
    check_eq("flush_ctrl", 64'(out_ctrl[1]), 64'(BUB));
    check_eq("flush_data", 64'(out_data[1]), 64'd0);
    check_eq("flush_occ", 64'(occupancy[1]), 64'd0);
    check_eq("flush_rdy", 64'(in_ready[1]), 64'd1);
    out_ready[1] = 1'b1;
    repeat (2) begin
      cyc();
      check_eq("flush_no_c", 64'(out_valid[1]), 64'd0);
    end
    // Flush while in_ready=1: the offered entry is still dropped.
    out_ready[1] = 1'b0;
    drive(1, 1'b1, 8'hAA, 47'h4); cyc();
    flush[1] = 1'b1;
    drive(1, 1'b1, 8'hCC, 47'h5); cyc();
    flush[1] = 1'b0;
    drive(1, 1'b0, 8'h00, 47'h0);
    check_eq("flush1_occ", 64'(occupancy[1]), 64'd0);
    cyc();
    check_eq("flush1_drop", 64'(occupancy[1]), 64'd0);

    // Single-entry build: combinational in_ready.
    drive(0, 1'b1, 8'hDD, 47'hD); cyc();
    drive(0, 1'b0, 8'h00, 47'h0);
    check_eq("s0_held_rdy", 64'(in_ready[0]), 64'd0);
    check_eq("s0_held_occ", 64'(occupancy[0]), 64'd1);
    out_ready[0] = 1'b1;
    #1;
    check_eq("s0_comb_rdy", 64'(in_ready[0]), 64'd1);
    drive(0, 1'b1, 8'hEE, 47'hE); cyc();
    drive(0, 1'b0, 8'h00, 47'h0);
    check_eq("s0_replace_ctrl", 64'(out_ctrl[0]), 64'hEE);
    check_eq("s0_replace_occ", 64'(occupancy[0]), 64'd1);
    cyc();
    check_eq("s0_empty", 64'(out_valid[0]), 64'd0);
    out_ready[0] = 1'b0;

    // Asynchronous reset mid-stream.
    drive(1, 1'b1, 8'hAA, 47'h6); cyc();
    drive(1, 1'b1, 8'hBB, 47'h7); cyc();
    drive(1, 1'b1, 8'hCC, 47'h8);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_valid", 64'(out_valid[1]), 64'd0);
    check_eq("arst_ctrl", 64'(out_ctrl[1]), 64'(BUB));
    check_eq("arst_data", 64'(out_data[1]), 64'd0);
    check_eq("arst_occ", 64'(occupancy[1]), 64'd0);
    check_eq("arst_rdy", 64'(in_ready[1]), 64'd1);
    drive(1, 1'b0, 8'h00, 47'h0);
    cyc();
    reset = 1'b0;
    cyc();
    check_eq("arst_after", 64'(occupancy[1]), 64'd0);

    // Random valid/ready/flush on both builds; scoreboards check every cycle.
    for (int n = 0; n < 10000; n++) begin
      for (int g = 0; g < 2; g++) begin
        flush[g]     = ($urandom_range(0, 63) == 0);
        out_ready[g] = 1'($urandom_range(0, 1));
        drive(g, 1'($urandom_range(0, 1)), CW'($urandom()), DW'({$urandom(), $urandom()}));
      end
      cyc();
    end
    for (int g = 0; g < 2; g++) begin
      flush[g] = 1'b0;
      out_ready[g] = 1'b1;
      drive(g, 1'b0, 8'h00, 47'h0);
    end
    repeat (4) cyc();
    check_eq("final_occ0", 64'(occupancy[0]), 64'd0);
    check_eq("final_occ1", 64'(occupancy[1]), 64'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
